// File: rtl/subadc_capture_if.sv
// Bundles the sub-ADC input side, the valid/ready result stream and the
// calibration status of subadc_capture into one port.
interface subadc_capture_if #(
    parameter int ADC_BITS = 8
);
    logic [ADC_BITS-1:0] subadc_data;
    logic                subadc_compl;
    logic [ADC_BITS-1:0] offset_in;
    logic                cal_start;
    logic [ADC_BITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                cal_busy;
    logic                cal_done;
    logic [ADC_BITS-1:0] cal_mean;
    logic [7:0]          ovf_cnt;

    // Environment side: drives the converter, offset and consumer ready.
    modport master (
        output subadc_data, subadc_compl, offset_in, cal_start, out_ready,
        input  out_data, out_valid, cal_busy, cal_done, cal_mean, ovf_cnt
    );

    // Capture block side.
    modport slave (
        input  subadc_data, subadc_compl, offset_in, cal_start, out_ready,
        output out_data, out_valid, cal_busy, cal_done, cal_mean, ovf_cnt
    );
endinterface

// File: rtl/subadc_capture.sv
// Back end of the SAR sub-ADC: synchronises the asynchronous completion
// level, captures each code, subtracts a signed offset with clamping to the
// unsigned code range, and queues results in a show-ahead FIFO. A separate
// calibration FSM averages a power-of-two number of raw codes on request.
module subadc_capture #(
    parameter int ADC_BITS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CAL_LOG2    = 4
) (
    input  logic           clk,
    input  logic           rst,
    subadc_capture_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ACC_W  = ADC_BITS + CAL_LOG2;
    localparam int DIFF_W = ADC_BITS + 2;

    localparam logic [PTR_W:0]    PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CAL_LOG2:0] N_ONE   = {{CAL_LOG2{1'b0}}, 1'b1};
    localparam logic [CAL_LOG2:0] N_LAST  = {1'b0, {CAL_LOG2{1'b1}}};

    typedef enum logic [1:0] {
        CAL_IDLE,
        CAL_ACCUM,
        CAL_DONE
    } cal_state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last_q;
    logic                   event_w;

    logic [ADC_BITS-1:0]    raw_q;
    logic [ADC_BITS-1:0]    offset_q;
    logic                   cap_vld_q;

    logic [DIFF_W-1:0]      diff_w;
    logic [ADC_BITS-1:0]    corr_w;

    logic [ADC_BITS-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr_q;
    logic [PTR_W:0]         rd_ptr_q;
    logic                   empty_w;
    logic                   full_w;
    logic                   pop_w;
    logic                   push_w;
    logic                   drop_w;
    logic [7:0]             ovf_q;

    cal_state_e             state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CAL_LOG2:0]      n_q, n_d;
    logic [ADC_BITS-1:0]    mean_q, mean_d;
    logic                   cal_busy_w;
    logic                   cal_done_w;

    // Synchronise the completion level and remember the last synced value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            sync_last_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.subadc_compl};
            sync_last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign event_w = sync_q[SYNC_STAGES-1] & ~sync_last_q;

    // Capture code and offset on the rising-edge event; data is stable while compl is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q     <= '0;
            offset_q  <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= event_w;
            if (event_w) begin
                raw_q    <= bus.subadc_data;
                offset_q <= bus.offset_in;
            end
        end
    end

    // Offset subtraction in two extra bits of headroom, then clamp to the unsigned code range.
    always_comb begin
        diff_w = {2'b00, raw_q} - {{2{offset_q[ADC_BITS-1]}}, offset_q};
        corr_w = diff_w[ADC_BITS-1:0];
        if (diff_w[DIFF_W-1]) begin
            corr_w = '0;
        end else if (diff_w[ADC_BITS]) begin
            corr_w = '1;
        end
    end

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_w   = !empty_w && bus.out_ready;
    assign push_w  = cap_vld_q && (!full_w || pop_w);
    assign drop_w  = cap_vld_q && full_w && !pop_w;

    // FIFO storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= corr_w;
        end
    end

    // FIFO pointers and saturating count of samples lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop_w && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end
        end
    end

    // Calibration state, accumulator, sample counter and last mean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CAL_IDLE;
            acc_q   <= '0;
            n_q     <= '0;
            mean_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            mean_q  <= mean_d;
        end
    end

    // Calibration next state: sums raw (uncorrected) codes, then publishes the truncated mean.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        n_d        = n_q;
        mean_d     = mean_q;
        cal_busy_w = 1'b0;
        cal_done_w = 1'b0;
        case (state_q)
            CAL_IDLE: begin
                if (bus.cal_start) begin
                    state_d = CAL_ACCUM;
                    acc_d   = '0;
                    n_d     = '0;
                end
            end
            CAL_ACCUM: begin
                cal_busy_w = 1'b1;
                if (cap_vld_q) begin
                    acc_d = acc_q + ACC_W'(raw_q);
                    n_d   = n_q + N_ONE;
                    if (n_q == N_LAST) begin
                        state_d = CAL_DONE;
                    end
                end
            end
            CAL_DONE: begin
                cal_done_w = 1'b1;
                mean_d     = ADC_BITS'(acc_q >> CAL_LOG2);
                state_d    = CAL_IDLE;
            end
            default: begin
                state_d = CAL_IDLE;
            end
        endcase
    end

    assign bus.out_data  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.out_valid = !empty_w;
    assign bus.cal_busy  = cal_busy_w;
    assign bus.cal_done  = cal_done_w;
    assign bus.cal_mean  = mean_q;
    assign bus.ovf_cnt   = ovf_q;
endmodule

// File: tb/tb_subadc_capture.sv
// Directed bench for subadc_capture. Each conversion pushes its hand-computed
// corrected code into a queue; a monitor pops and compares on every accepted
// output beat. Status outputs are checked directly at chosen points.
module tb_subadc_capture;
    localparam int ADC_BITS    = 8;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst;

    int total     = 0;
    int bad       = 0;
    int popCount  = 0;
    int doneCount = 0;

    logic [7:0] expQ[$];

    subadc_capture_if #(.ADC_BITS(ADC_BITS)) bus ();

    subadc_capture #(
        .ADC_BITS   (ADC_BITS),
        .SYNC_STAGES(SYNC_STAGES),
        .FIFO_DEPTH (4),
        .CAL_LOG2   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Record one comparison and report it when it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion: compl high for 'hold' cycles, then low long enough to re-arm.
    task automatic applyStimulus(input logic [7:0] data, input logic [7:0] offset,
                                 input int hold, input logic [7:0] expected, input bit keep);
        bus.subadc_data  = data;
        bus.offset_in    = offset;
        bus.subadc_compl = 1'b1;
        if (keep) expQ.push_back(expected);
        repeat (hold) tick();
        bus.subadc_compl = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
    endtask

    // Accept everything until the scoreboard and the FIFO are both empty, bounded.
    task automatic drainAll();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64 && (expQ.size() != 0 || bus.out_valid); i++) tick();
        checkOutput("drainQueue", expQ.size(), 0);
        checkOutput("drainValid", bus.out_valid, 0);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cal_done) doneCount++;
            if (bus.out_valid && bus.out_ready) begin
                popCount++;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedOutput: got 0x%0h, wanted no output", bus.out_data);
                end else begin
                    checkOutput("outData", bus.out_data, expQ.pop_front());
                end
            end
        end
    end

    // Runaway guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int popBefore;
        int doneBefore;

        rst              = 1'b1;
        bus.subadc_data  = '0;
        bus.subadc_compl = 1'b0;
        bus.offset_in    = '0;
        bus.cal_start    = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (3) tick();
        checkOutput("rstValid", bus.out_valid, 0);
        checkOutput("rstBusy", bus.cal_busy, 0);
        checkOutput("rstDone", bus.cal_done, 0);
        checkOutput("rstMean", bus.cal_mean, 0);
        checkOutput("rstOvf", bus.ovf_cnt, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single conversion and latency");
        popBefore        = popCount;
        bus.subadc_data  = 8'h5A;
        bus.offset_in    = 8'h00;
        expQ.push_back(8'h5A);
        bus.subadc_compl = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("latencyEdge3", bus.out_valid, 0);
        tick();
        checkOutput("latencyEdge4", bus.out_valid, 1);
        checkOutput("headData", bus.out_data, 8'h5A);
        bus.subadc_compl = 1'b0;
        bus.out_ready    = 1'b1;
        tick();
        bus.out_ready    = 1'b0;
        checkOutput("popClears", bus.out_valid, 0);
        checkOutput("onePop", popCount - popBefore, 1);
        repeat (3) tick();

        $display("[TB] offset correction and clamping");
        bus.out_ready = 1'b1;
        applyStimulus(8'h05, 8'h10, 1, 8'h00, 1'b1);
        applyStimulus(8'hF8, 8'hF0, 1, 8'hFF, 1'b1);
        applyStimulus(8'h80, 8'h03, 1, 8'h7D, 1'b1);
        drainAll();

        $display("[TB] overflow while stalled");
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(8'(i), 8'h00, 1, 8'(i), i <= 4);
        end
        checkOutput("ovfTwo", bus.ovf_cnt, 2);
        checkOutput("fullValid", bus.out_valid, 1);
        drainAll();

        $display("[TB] calibration run");
        bus.out_ready = 1'b1;
        doneBefore    = doneCount;
        bus.cal_start = 1'b1;
        tick();
        bus.cal_start = 1'b0;
        checkOutput("calBusy", bus.cal_busy, 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i % 2) ? 8'h41 : 8'h40, 8'h00, 1, (i % 2) ? 8'h41 : 8'h40, 1'b1);
        end
        checkOutput("calDonePulses", doneCount - doneBefore, 1);
        checkOutput("calMean", bus.cal_mean, 8'h40);
        checkOutput("calIdle", bus.cal_busy, 0);
        drainAll();

        $display("[TB] reset during calibration");
        doneBefore    = doneCount;
        bus.cal_start = 1'b1;
        tick();
        bus.cal_start = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(8'h20, 8'h00, 1, 8'h20, 1'b1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus(8'h21, 8'h00, 1, 8'h21, 1'b1);
        checkOutput("preRstValid", bus.out_valid, 1);
        checkOutput("preRstBusy", bus.cal_busy, 1);
        rst = 1'b1;
        expQ.delete();
        tick();
        tick();
        checkOutput("abortBusy", bus.cal_busy, 0);
        checkOutput("abortValid", bus.out_valid, 0);
        checkOutput("abortMean", bus.cal_mean, 0);
        checkOutput("abortOvf", bus.ovf_cnt, 0);
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("abortNoDone", doneCount - doneBefore, 0);
        checkOutput("postRstValid", bus.out_valid, 0);

        $display("[TB] long compl and full push/pop");
        bus.out_ready = 1'b1;
        popBefore     = popCount;
        applyStimulus(8'h33, 8'h00, 20, 8'h33, 1'b1);
        repeat (3) tick();
        checkOutput("longComplPops", popCount - popBefore, 1);
        checkOutput("longComplEmpty", bus.out_valid, 0);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'h11 + 8'(i), 8'h00, 1, 8'h11 + 8'(i), 1'b1);
        checkOutput("fullBeforeSwap", bus.out_valid, 1);
        bus.subadc_data  = 8'h15;
        bus.offset_in    = 8'h00;
        expQ.push_back(8'h15);
        bus.subadc_compl = 1'b1;
        tick();
        bus.subadc_compl = 1'b0;
        tick();
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        repeat (3) tick();
        checkOutput("swapNoDrop", bus.ovf_cnt, 0);
        drainAll();

        checkOutput("finalQueue", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
